// File: rtl/cache_controller.sv
// Blocking controller for a direct-mapped, write-back cache with one CPU requester.
// Splits the latched word address into tag/index/offset, sequences lookup,
// write-back, allocate and refill, and keeps saturating hit/miss/write-back counters.
module cache_controller #(
    parameter int TAG_W    = 24,
    parameter int INDEX_W  = 6,
    parameter int OFFSET_W = 2,
    parameter int CNT_W    = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cpu_req_valid,
    input  logic                cpu_req_type,
    input  logic [31:0]         cpu_addr,
    input  logic [31:0]         cpu_wdata,
    output logic                cpu_ready,
    output logic                cpu_done,
    output logic [31:0]         cpu_rdata,
    output logic [TAG_W-1:0]    cache_tag,
    output logic [INDEX_W-1:0]  cache_index,
    output logic [OFFSET_W-1:0] cache_blk_offset,
    output logic                cache_req_type,
    output logic                cache_read_en,
    output logic                cache_write_en,
    output logic                cache_refill,
    output logic [31:0]         cache_wdata,
    input  logic                cache_hit,
    input  logic                cache_dirty,
    input  logic [31:0]         cache_rdata,
    input  logic [TAG_W-1:0]    cache_victim_tag,
    output logic                mem_rd_req,
    output logic                mem_wr_req,
    output logic [31:0]         mem_addr,
    input  logic                mem_ack,
    output logic [CNT_W-1:0]    hit_cnt,
    output logic [CNT_W-1:0]    miss_cnt,
    output logic [CNT_W-1:0]    wb_cnt
);

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        DECIDE,
        WRITEBACK,
        ALLOCATE,
        REFILL
    } state_t;

    state_t      state, state_nxt;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic        type_q;
    logic        retry_q;   // set by a refill so the retry hit is not counted twice

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // Address fields and write data come straight from the latched request.
    assign cache_tag        = addr_q[OFFSET_W+INDEX_W +: TAG_W];
    assign cache_index      = addr_q[OFFSET_W +: INDEX_W];
    assign cache_blk_offset = addr_q[OFFSET_W-1:0];
    assign cache_req_type   = type_q;
    assign cache_wdata      = wdata_q;

    // Next-state decode and per-state strobes.
    always_comb begin
        state_nxt      = state;
        cpu_ready      = 1'b0;
        cache_read_en  = 1'b0;
        cache_write_en = 1'b0;
        cache_refill   = 1'b0;
        mem_rd_req     = 1'b0;
        mem_wr_req     = 1'b0;
        mem_addr       = {cache_tag, cache_index, {OFFSET_W{1'b0}}};
        case (state)
            IDLE: begin
                cpu_ready = 1'b1;
                if (cpu_req_valid) state_nxt = LOOKUP;
            end
            LOOKUP: begin
                cache_read_en  = ~type_q;
                cache_write_en = type_q;
                state_nxt      = DECIDE;
            end
            DECIDE: begin
                if (cache_hit)        state_nxt = IDLE;
                else if (cache_dirty) state_nxt = WRITEBACK;
                else                  state_nxt = ALLOCATE;
            end
            WRITEBACK: begin
                mem_wr_req = 1'b1;
                mem_addr   = {cache_victim_tag, cache_index, {OFFSET_W{1'b0}}};
                if (mem_ack) state_nxt = ALLOCATE;
            end
            ALLOCATE: begin
                mem_rd_req = 1'b1;
                if (mem_ack) state_nxt = REFILL;
            end
            REFILL: begin
                cache_refill   = 1'b1;
                cache_write_en = 1'b1;
                state_nxt      = LOOKUP;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register, request latch, completion pulse, read data and counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            type_q    <= 1'b0;
            retry_q   <= 1'b0;
            cpu_done  <= 1'b0;
            cpu_rdata <= '0;
            hit_cnt   <= '0;
            miss_cnt  <= '0;
            wb_cnt    <= '0;
        end else begin
            state    <= state_nxt;
            cpu_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (cpu_req_valid) begin
                        addr_q  <= cpu_addr;
                        wdata_q <= cpu_wdata;
                        type_q  <= cpu_req_type;
                        retry_q <= 1'b0;
                    end
                end
                DECIDE: begin
                    if (cache_hit) begin
                        cpu_done <= 1'b1;
                        retry_q  <= 1'b0;
                        if (!type_q)  cpu_rdata <= cache_rdata;
                        if (!retry_q) hit_cnt   <= sat_inc(hit_cnt);
                    end else begin
                        miss_cnt <= sat_inc(miss_cnt);
                    end
                end
                WRITEBACK: begin
                    if (mem_ack) wb_cnt <= sat_inc(wb_cnt);
                end
                REFILL: retry_q <= 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cache_controller.sv
// Directed bench for cache_controller: a behavioural cache array and main memory
// surround the DUT; a vector table drives single transactions and hand-written
// sequences cover reset during a fill and counter saturation.
module tb_cache_controller;

    logic        clk, rst;
    logic        cpu_req_valid, cpu_req_type;
    logic [31:0] cpu_addr, cpu_wdata;
    logic        cpu_ready, cpu_done;
    logic [31:0] cpu_rdata;
    logic [23:0] cache_tag;
    logic [5:0]  cache_index;
    logic [1:0]  cache_blk_offset;
    logic        cache_req_type, cache_read_en, cache_write_en, cache_refill;
    logic [31:0] cache_wdata;
    logic        m_hit, m_dirty;
    logic [31:0] m_rdata;
    logic [23:0] cache_victim_tag;
    logic        mem_rd_req, mem_wr_req, mem_ack;
    logic [31:0] mem_addr;
    logic [15:0] hit_cnt, miss_cnt, wb_cnt;

    // second instance with 2-bit counters, cache always hitting
    logic        s_valid, s_ready, s_done, s_rd_en, s_wr_en, s_refill, s_req_type;
    logic        s_mem_rd, s_mem_wr;
    logic [31:0] s_rdata, s_wdata_o, s_mem_addr;
    logic [23:0] s_tag;
    logic [5:0]  s_index;
    logic [1:0]  s_off, s_hit_cnt, s_miss_cnt, s_wb_cnt;

    int n_chk = 0;
    int n_err = 0;
    int ack_delay = 1;
    int both_high = 0;

    cache_controller dut (
        .clk(clk), .rst(rst),
        .cpu_req_valid(cpu_req_valid), .cpu_req_type(cpu_req_type),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ready(cpu_ready), .cpu_done(cpu_done), .cpu_rdata(cpu_rdata),
        .cache_tag(cache_tag), .cache_index(cache_index),
        .cache_blk_offset(cache_blk_offset), .cache_req_type(cache_req_type),
        .cache_read_en(cache_read_en), .cache_write_en(cache_write_en),
        .cache_refill(cache_refill), .cache_wdata(cache_wdata),
        .cache_hit(m_hit), .cache_dirty(m_dirty), .cache_rdata(m_rdata),
        .cache_victim_tag(cache_victim_tag),
        .mem_rd_req(mem_rd_req), .mem_wr_req(mem_wr_req), .mem_addr(mem_addr),
        .mem_ack(mem_ack),
        .hit_cnt(hit_cnt), .miss_cnt(miss_cnt), .wb_cnt(wb_cnt)
    );

    cache_controller #(.CNT_W(2)) sat_dut (
        .clk(clk), .rst(rst),
        .cpu_req_valid(s_valid), .cpu_req_type(1'b0),
        .cpu_addr(32'h0000_0010), .cpu_wdata(32'h0),
        .cpu_ready(s_ready), .cpu_done(s_done), .cpu_rdata(s_rdata),
        .cache_tag(s_tag), .cache_index(s_index),
        .cache_blk_offset(s_off), .cache_req_type(s_req_type),
        .cache_read_en(s_rd_en), .cache_write_en(s_wr_en),
        .cache_refill(s_refill), .cache_wdata(s_wdata_o),
        .cache_hit(1'b1), .cache_dirty(1'b0), .cache_rdata(32'h1234_5678),
        .cache_victim_tag(24'h0),
        .mem_rd_req(s_mem_rd), .mem_wr_req(s_mem_wr), .mem_addr(s_mem_addr),
        .mem_ack(1'b0),
        .hit_cnt(s_hit_cnt), .miss_cnt(s_miss_cnt), .wb_cnt(s_wb_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- behavioural cache array and main memory ----------------
    logic        lv [64];
    logic        ld [64];
    logic [23:0] lt [64];
    logic [31:0] lw [64][4];
    logic [31:0] mem_w [logic [31:0]];

    assign cache_victim_tag = lt[cache_index];

    // Registered lookup; refill pulls the block from memory; write-back stores the victim.
    always @(posedge clk) begin
        logic        h;
        logic [31:0] a;
        if (rst) begin
            for (int i = 0; i < 64; i++) begin
                lv[i] = 1'b0; ld[i] = 1'b0; lt[i] = '0;
                for (int w = 0; w < 4; w++) lw[i][w] = '0;
            end
            lv[0] = 1'b1; lt[0] = 24'hABCDE0;
            lv[1] = 1'b1; lt[1] = 24'h000ABC;
            lv[2] = 1'b1; lt[2] = 24'h222222;
            lv[3] = 1'b1; lt[3] = 24'h111111; ld[3] = 1'b1;
            lv[4] = 1'b1; lt[4] = 24'h555555;
            for (int w = 0; w < 4; w++) begin
                lw[0][w] = 32'hA0A0_0000 + w;
                lw[1][w] = 32'hB1B1_0000 + w;
                lw[2][w] = 32'hC2C2_0000 + w;
                lw[3][w] = 32'hD3D3_0000 + w;
                lw[4][w] = 32'hE4E4_0000 + w;
            end
            m_hit   <= 1'b0;
            m_dirty <= 1'b0;
            m_rdata <= '0;
        end else begin
            if (mem_ack && mem_wr_req)
                for (int w = 0; w < 4; w++)
                    mem_w[{mem_addr[31:2], 2'(w)}] = lw[cache_index][w];
            if (cache_refill) begin
                for (int w = 0; w < 4; w++) begin
                    a = {cache_tag, cache_index, 2'(w)};
                    lw[cache_index][w] = mem_w.exists(a) ? mem_w[a] : (a ^ 32'h5A5A_0000);
                end
                lv[cache_index] = 1'b1;
                lt[cache_index] = cache_tag;
                ld[cache_index] = 1'b0;
            end else if (cache_read_en || cache_write_en) begin
                h = lv[cache_index] && (lt[cache_index] == cache_tag);
                m_hit   <= h;
                m_dirty <= ld[cache_index];
                m_rdata <= lw[cache_index][cache_blk_offset];
                if (h && cache_write_en) begin
                    lw[cache_index][cache_blk_offset] = cache_wdata;
                    ld[cache_index] = 1'b1;
                end
            end
        end
    end

    // Memory responder: acknowledges a pending request after ack_delay waiting cycles.
    initial begin
        int wcnt;
        mem_ack = 1'b0;
        wcnt = 0;
        forever begin
            @(posedge clk);
            #1;
            if (mem_ack || rst) begin
                mem_ack = 1'b0;
                wcnt = 0;
            end else if (mem_rd_req || mem_wr_req) begin
                if (wcnt >= ack_delay) mem_ack = 1'b1;
                else wcnt++;
            end else begin
                wcnt = 0;
            end
        end
    end

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          dly;
        logic [31:0] exp_rdata;
        logic        is_miss;      // latency measured from ack cycle instead of accept edge
        logic [15:0] exp_hit;
        logic [15:0] exp_miss;
        logic [15:0] exp_wb;
        logic        exp_wrq;
        logic [31:0] exp_wr_addr;
        logic        exp_rdq;
        logic [31:0] exp_rd_addr;
    } vec_t;

    vec_t vecs[6];

    task automatic run_vec(input int i);
        vec_t        t;
        int          edges, ack_at, done_at, refills;
        logic        wr_seen, rd_seen, wr_before_rd;
        logic [31:0] wa, ra;
        t = vecs[i];
        ack_delay = t.dly;
        @(negedge clk);
        cpu_req_valid = 1'b1; cpu_req_type = t.wr; cpu_addr = t.addr; cpu_wdata = t.wdata;
        @(posedge clk);
        @(negedge clk);
        cpu_req_valid = 1'b0; cpu_addr = 32'hFFFF_FFFF; cpu_wdata = 32'h0BAD_F00D;
        edges = 0; ack_at = -100; done_at = -1; refills = 0;
        wr_seen = 1'b0; rd_seen = 1'b0; wr_before_rd = 1'b0; wa = '0; ra = '0;
        while (done_at < 0 && edges < 300) begin
            if (cpu_done) begin
                done_at = edges;
            end else begin
                if (mem_wr_req && mem_rd_req) both_high++;
                if (mem_wr_req && !wr_seen) begin wr_seen = 1'b1; wa = mem_addr; end
                if (mem_rd_req && !rd_seen) begin rd_seen = 1'b1; ra = mem_addr; wr_before_rd = wr_seen; end
                if (mem_rd_req && mem_ack) ack_at = edges;
                if (cache_refill) refills++;
                @(posedge clk);
                edges++;
                @(negedge clk);
            end
        end
        if (t.is_miss) check($sformatf("v%0d latency after ack", i), done_at - ack_at, 4);
        else           check($sformatf("v%0d latency", i), done_at, 2);
        if (!t.wr) check($sformatf("v%0d cpu_rdata", i), cpu_rdata, t.exp_rdata);
        check($sformatf("v%0d hit_cnt", i), 32'(hit_cnt), 32'(t.exp_hit));
        check($sformatf("v%0d miss_cnt", i), 32'(miss_cnt), 32'(t.exp_miss));
        check($sformatf("v%0d wb_cnt", i), 32'(wb_cnt), 32'(t.exp_wb));
        check($sformatf("v%0d wr_req seen", i), 32'(wr_seen), 32'(t.exp_wrq));
        check($sformatf("v%0d rd_req seen", i), 32'(rd_seen), 32'(t.exp_rdq));
        check($sformatf("v%0d refill pulses", i), refills, t.exp_rdq ? 1 : 0);
        if (t.exp_wrq) check($sformatf("v%0d wb addr", i), wa, t.exp_wr_addr);
        if (t.exp_rdq) check($sformatf("v%0d fetch addr", i), ra, t.exp_rd_addr);
        if (t.exp_wrq) check($sformatf("v%0d wb before fetch", i), 32'(wr_before_rd), 32'd1);
        @(posedge clk);
        @(negedge clk);
        check($sformatf("v%0d done pulse width", i), 32'(cpu_done), 32'd0);
        check($sformatf("v%0d ready after", i), 32'(cpu_ready), 32'd1);
    endtask

    task automatic sat_req(output int lat);
        @(negedge clk);
        s_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        s_valid = 1'b0;
        lat = 0;
        while (!s_done && lat < 20) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int lat, dones;
        logic seen;
        vecs[0] = '{wr:1'b0, addr:32'hABCDE003, wdata:32'h0, dly:1, exp_rdata:32'hA0A00003,
                    is_miss:1'b0, exp_hit:16'd1, exp_miss:16'd0, exp_wb:16'd0,
                    exp_wrq:1'b0, exp_wr_addr:32'h0, exp_rdq:1'b0, exp_rd_addr:32'h0};
        vecs[1] = '{wr:1'b1, addr:32'h000ABC07, wdata:32'hCAFEBABE, dly:1, exp_rdata:32'h0,
                    is_miss:1'b0, exp_hit:16'd2, exp_miss:16'd0, exp_wb:16'd0,
                    exp_wrq:1'b0, exp_wr_addr:32'h0, exp_rdq:1'b0, exp_rd_addr:32'h0};
        vecs[2] = '{wr:1'b0, addr:32'h33333309, wdata:32'h0, dly:3, exp_rdata:32'h69693309,
                    is_miss:1'b1, exp_hit:16'd2, exp_miss:16'd1, exp_wb:16'd0,
                    exp_wrq:1'b0, exp_wr_addr:32'h0, exp_rdq:1'b1, exp_rd_addr:32'h33333308};
        vecs[3] = '{wr:1'b0, addr:32'h4444440E, wdata:32'h0, dly:0, exp_rdata:32'h1E1E440E,
                    is_miss:1'b1, exp_hit:16'd2, exp_miss:16'd2, exp_wb:16'd1,
                    exp_wrq:1'b1, exp_wr_addr:32'h1111110C, exp_rdq:1'b1, exp_rd_addr:32'h4444440C};
        vecs[4] = '{wr:1'b1, addr:32'h66666613, wdata:32'h4AFEBABE, dly:2, exp_rdata:32'h0,
                    is_miss:1'b1, exp_hit:16'd2, exp_miss:16'd3, exp_wb:16'd1,
                    exp_wrq:1'b0, exp_wr_addr:32'h0, exp_rdq:1'b1, exp_rd_addr:32'h66666610};
        vecs[5] = '{wr:1'b0, addr:32'h66666613, wdata:32'h0, dly:1, exp_rdata:32'h4AFEBABE,
                    is_miss:1'b0, exp_hit:16'd3, exp_miss:16'd3, exp_wb:16'd1,
                    exp_wrq:1'b0, exp_wr_addr:32'h0, exp_rdq:1'b0, exp_rd_addr:32'h0};

        rst = 1'b1; cpu_req_valid = 1'b0; cpu_req_type = 1'b0;
        cpu_addr = '0; cpu_wdata = '0; s_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        check("reset cpu_ready", 32'(cpu_ready), 32'd1);
        check("reset cpu_done", 32'(cpu_done), 32'd0);
        check("reset cpu_rdata", cpu_rdata, 32'h0);
        check("reset counters", {hit_cnt, miss_cnt | wb_cnt}, 32'h0);
        check("reset requests", {28'h0, mem_rd_req, mem_wr_req, cache_read_en, cache_write_en}, 32'h0);
        check("reset refill", 32'(cache_refill), 32'd0);
        check("reset latched index", 32'(cache_index), 32'd0);

        for (int i = 0; i < 6; i++) run_vec(i);

        check("write hit word", lw[1][3], 32'hCAFEBABE);
        check("write hit dirty", 32'(ld[1]), 32'd1);
        check("write miss word", lw[4][3], 32'h4AFEBABE);
        check("write miss dirty", 32'(ld[4]), 32'd1);
        check("victim word0 in mem", mem_w.exists(32'h1111110C) ? mem_w[32'h1111110C] : 32'hX, 32'hD3D30000);
        check("victim word3 in mem", mem_w.exists(32'h1111110F) ? mem_w[32'h1111110F] : 32'hX, 32'hD3D30003);
        check("rd and wr never both high", both_high, 0);

        // reset while a fetch is outstanding
        ack_delay = 1000;
        @(negedge clk);
        cpu_req_valid = 1'b1; cpu_req_type = 1'b0; cpu_addr = 32'h77777714;
        @(posedge clk);
        @(negedge clk);
        cpu_req_valid = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            if (mem_rd_req) seen = 1'b1;
            else begin @(posedge clk); @(negedge clk); end
        end
        check("fetch raised before reset", 32'(seen), 32'd1);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("reset drops mem_rd_req", 32'(mem_rd_req), 32'd0);
        check("reset mem_wr_req", 32'(mem_wr_req), 32'd0);
        check("reset back to idle", 32'(cpu_ready), 32'd1);
        check("reset clears miss_cnt", 32'(miss_cnt), 32'd0);
        rst = 1'b0;
        dones = 0;
        for (int c = 0; c < 8; c++) begin
            if (cpu_done || mem_rd_req) dones++;
            @(posedge clk);
            @(negedge clk);
        end
        check("abandoned request silent", dones, 0);
        ack_delay = 1;

        // saturation with 2-bit counters
        sat_req(lat);
        check("sat hit latency", lat, 2);
        sat_req(lat);
        check("sat hit_cnt after 2", 32'(s_hit_cnt), 32'd2);
        for (int k = 0; k < 3; k++) sat_req(lat);
        check("sat hit_cnt after 5", 32'(s_hit_cnt), 32'd3);
        check("sat miss_cnt", 32'(s_miss_cnt), 32'd0);
        check("sat rdata", s_rdata, 32'h12345678);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
